// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode constants and FSM state type shared by the
// accumulator ALU (alu_seq), its bus interface and its multiplier.
package alu_seq_pkg;

    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_LDI  = 1;
    localparam int unsigned OP_ADD  = 2;
    localparam int unsigned OP_NOT  = 3;
    localparam int unsigned OP_AND  = 4;
    localparam int unsigned OP_XOR  = 5;
    localparam int unsigned OP_STA  = 6;
    localparam int unsigned OP_DISP = 7;
    localparam int unsigned OP_SUB  = 8;
    localparam int unsigned OP_SHL  = 9;
    localparam int unsigned OP_SHR  = 10;
    localparam int unsigned OP_OR   = 11;
    localparam int unsigned OP_MUL  = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: op request / result bus of alu_seq.
//   master (requester): drives in_valid, op, inp; observes the rest.
//   slave  (alu_seq)  : drives in_ready, out_valid, outp, flag_z, flag_c, acc.
interface alu_seq_if #(
    parameter int SIZE   = 8,
    parameter int OPSIZE = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [OPSIZE-1:0] op;
    logic [SIZE-1:0]   inp;
    logic              out_valid;
    logic [SIZE-1:0]   outp;
    logic              flag_z;
    logic              flag_c;
    logic [SIZE-1:0]   acc;

    modport master (
        output in_valid, op, inp,
        input  in_ready, out_valid, outp, flag_z, flag_c, acc
    );

    modport slave (
        input  in_valid, op, inp,
        output in_ready, out_valid, outp, flag_z, flag_c, acc
    );
endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst : clock, async active-high reset
//   start    : latch a, b and begin (ignored while busy)
//   a, b     : SIZE-bit operands
//   busy     : iterations in progress (SIZE cycles after start)
//   done     : high during the cycle whose edge performs the final iteration
//   product  : 2*SIZE-bit result, final once busy drops
module alu_seq_mul #(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] product
);
    localparam int CW = $clog2(SIZE + 1);

    logic [2*SIZE-1:0] mcand;
    logic [SIZE-1:0]   mplr;
    logic [CW-1:0]     cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            product <= '0;
        end else if (start && !busy) begin
            mcand   <= {{SIZE{1'b0}}, a};
            mplr    <= b;
            cnt     <= CW'(SIZE);
            busy    <= 1'b1;
            product <= '0;
        end else if (busy) begin
            if (mplr[0])
                product <= product + mcand;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt - 1'b1;
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

    // Combinational so the controller can leave its run state on the same
    // edge that adds the last partial product.
    assign done = busy && (cnt == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// alu_seq: accumulator ALU with a single-cycle datapath and an optional
// iterative multiplier.
//   clk, rst : clock, async active-high reset
//   bus      : alu_seq_if.slave -- op/inp request with valid/ready,
//              registered outp/flag_z/flag_c with a one-cycle out_valid,
//              live accumulator value on acc
// Build option: define ALU_SEQ_MUL_EN to include MUL (opcode 12) and the
// MUL_RUN/MUL_DONE states; otherwise opcode 12 is a NOP and in_ready is 1.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int OPSIZE = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    logic [SIZE-1:0] acc_q, outp_q, res;
    logic            z_q, c_q, ov_q, c_nx, wr_acc, upd_flags, in_ready, accept, single;
    logic [SIZE:0]   sum;

`ifdef ALU_SEQ_MUL_EN
    state_t            state, state_nx;
    logic              is_mul, mul_busy, mul_done;
    logic [2*SIZE-1:0] prod;

    assign is_mul   = (bus.op == OPSIZE'(OP_MUL));
    assign in_ready = (state == IDLE);
    assign single   = accept && !is_mul;

    alu_seq_mul #(.SIZE(SIZE)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (acc_q),
        .b       (bus.inp),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept && is_mul) state_nx = MUL_RUN;
            // An idle multiplier here can only mean it already finished.
            MUL_RUN:  if (mul_done || !mul_busy) state_nx = MUL_DONE;
            MUL_DONE: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
`else
    assign in_ready = 1'b1;
    assign single   = accept;
`endif

    assign accept = bus.in_valid && in_ready;

    // Single-cycle result. NOP and reserved opcodes fall to the default arm:
    // outp shows acc and both flags hold.
    always_comb begin
        res       = acc_q;
        c_nx      = 1'b0;
        wr_acc    = 1'b0;
        upd_flags = 1'b1;
        sum       = '0;
        case (bus.op)
            OPSIZE'(OP_LDI):  begin res = bus.inp; wr_acc = 1'b1; end
            OPSIZE'(OP_ADD):  begin
                sum = {1'b0, acc_q} + {1'b0, bus.inp};
                res = sum[SIZE-1:0]; c_nx = sum[SIZE]; wr_acc = 1'b1;
            end
            OPSIZE'(OP_NOT):  begin res = ~bus.inp; wr_acc = 1'b1; end
            OPSIZE'(OP_AND):  begin res = acc_q & bus.inp; wr_acc = 1'b1; end
            OPSIZE'(OP_XOR):  begin res = acc_q ^ bus.inp; wr_acc = 1'b1; end
            OPSIZE'(OP_STA):  res = acc_q;
            OPSIZE'(OP_DISP): res = bus.inp;
            OPSIZE'(OP_SUB):  begin
                // Bit SIZE of the extended difference is the borrow.
                sum = {1'b0, acc_q} - {1'b0, bus.inp};
                res = sum[SIZE-1:0]; c_nx = sum[SIZE]; wr_acc = 1'b1;
            end
            OPSIZE'(OP_SHL):  begin res = {acc_q[SIZE-2:0], 1'b0}; c_nx = acc_q[SIZE-1]; wr_acc = 1'b1; end
            OPSIZE'(OP_SHR):  begin res = {1'b0, acc_q[SIZE-1:1]}; c_nx = acc_q[0]; wr_acc = 1'b1; end
            OPSIZE'(OP_OR):   begin res = acc_q | bus.inp; wr_acc = 1'b1; end
            default:          upd_flags = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            outp_q <= '0;
            z_q    <= 1'b1;
            c_q    <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            ov_q <= 1'b0;
            if (single) begin
                ov_q   <= 1'b1;
                outp_q <= res;
                if (wr_acc) acc_q <= res;
                if (upd_flags) begin
                    z_q <= (res == '0);
                    c_q <= c_nx;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            // Product is final throughout MUL_DONE; commit it on the exit edge.
            if (state == MUL_DONE) begin
                ov_q   <= 1'b1;
                outp_q <= prod[SIZE-1:0];
                acc_q  <= prod[SIZE-1:0];
                z_q    <= (prod[SIZE-1:0] == '0);
                c_q    <= |prod[2*SIZE-1:SIZE];
            end
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ov_q;
    assign bus.outp      = outp_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
    assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, table-driven bench for alu_seq (SIZE=8, OPSIZE=4).
// MUL scenarios are compiled in when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int SIZE   = 8;
    localparam int OPSIZE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.SIZE(SIZE), .OPSIZE(OPSIZE)) bus ();

    alu_seq #(.SIZE(SIZE), .OPSIZE(OPSIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] inp;
        logic [7:0] outp;
        logic       z;
        logic       c;
        logic [7:0] acc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endtask

    task automatic add(input int unsigned op, input logic [7:0] inp, input logic [7:0] outp,
                       input logic z, input logic c, input logic [7:0] acc);
        vec_t v;
        v.op = 4'(op); v.inp = inp; v.outp = outp; v.z = z; v.c = c; v.acc = acc;
        vecs.push_back(v);
    endtask

    // One op presented for a single cycle; returns #1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [7:0] inp);
        @(negedge clk);
        bus.op = op; bus.inp = inp; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic mul_run(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp, input logic ez, input logic ec);
        int low = 0;
        int seen = -1;
        send(4'(OP_LDI), a);
        @(negedge clk);
        bus.op = 4'(OP_MUL); bus.inp = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        // Keep requesting a load while busy; it must not be taken.
        bus.op = 4'(OP_LDI); bus.inp = 8'h77;
        for (int k = 0; k < 20 && seen < 0; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (!bus.in_ready) low++;
            if (bus.out_valid) begin seen = k; bus.in_valid = 1'b0; end
        end
        bus.in_valid = 1'b0;
        chk("mul in_ready low cycles", low, 9);
        chk("mul out_valid latency", seen, 9);
        chk("mul outp", bus.outp, exp);
        chk("mul acc", bus.acc, exp);
        chk("mul flag_z", bus.flag_z, ez);
        chk("mul flag_c", bus.flag_c, ec);
        @(posedge clk); #1;
        chk("mul out_valid pulse", bus.out_valid, 0);
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.inp      = '0;

        //        op       inp    outp   z  c  acc
        add(OP_ADD,  8'h20, 8'h10, 0, 1, 8'h10);
        add(OP_LDI,  8'h05, 8'h05, 0, 0, 8'h05);
        add(OP_SUB,  8'h05, 8'h00, 1, 0, 8'h00);
        add(OP_SUB,  8'h01, 8'hFF, 0, 1, 8'hFF);
        add(OP_LDI,  8'h81, 8'h81, 0, 0, 8'h81);
        add(OP_SHL,  8'h00, 8'h02, 0, 1, 8'h02);
        add(OP_SHR,  8'h00, 8'h01, 0, 0, 8'h01);
        add(OP_STA,  8'h00, 8'h01, 0, 0, 8'h01);
        add(OP_DISP, 8'hAA, 8'hAA, 0, 0, 8'h01);
        add(OP_NOT,  8'h0F, 8'hF0, 0, 0, 8'hF0);
        add(OP_AND,  8'h3C, 8'h30, 0, 0, 8'h30);
        add(OP_XOR,  8'h30, 8'h00, 1, 0, 8'h00);
        add(OP_OR,   8'h5A, 8'h5A, 0, 0, 8'h5A);
        add(OP_NOP,  8'h00, 8'h5A, 0, 0, 8'h5A);
        add(OP_ADD,  8'hFF, 8'h59, 0, 1, 8'h59);
        add(OP_NOP,  8'h00, 8'h59, 0, 1, 8'h59);
        add(13,      8'h12, 8'h59, 0, 1, 8'h59);
        add(OP_LDI,  8'h00, 8'h00, 1, 0, 8'h00);
        add(OP_SHR,  8'h00, 8'h00, 1, 0, 8'h00);
        add(OP_LDI,  8'h80, 8'h80, 0, 0, 8'h80);
        add(OP_SHL,  8'h00, 8'h00, 1, 1, 8'h00);

        // Reset state, then the first op on the first edge after release.
        repeat (2) @(negedge clk);
        chk("reset acc", bus.acc, 0);
        chk("reset outp", bus.outp, 0);
        chk("reset flag_z", bus.flag_z, 1);
        chk("reset flag_c", bus.flag_c, 0);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset in_ready", bus.in_ready, 1);
        rst = 1'b0;
        bus.op = 4'(OP_LDI); bus.inp = 8'hF0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("first op out_valid", bus.out_valid, 1);
        chk("first op outp", bus.outp, 8'hF0);
        chk("first op acc", bus.acc, 8'hF0);
        @(posedge clk); #1;
        chk("first op pulse ends", bus.out_valid, 0);

        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].inp);
            chk($sformatf("v%0d out_valid", i), bus.out_valid, 1);
            chk($sformatf("v%0d outp", i), bus.outp, vecs[i].outp);
            chk($sformatf("v%0d flag_z", i), bus.flag_z, vecs[i].z);
            chk($sformatf("v%0d flag_c", i), bus.flag_c, vecs[i].c);
            chk($sformatf("v%0d acc", i), bus.acc, vecs[i].acc);
        end

        // Back-to-back ops, in_valid held every cycle from acc = 0x0F.
        send(4'(OP_LDI), 8'h0F);
        begin
            logic [3:0] bops [5];
            logic [7:0] bin  [5];
            logic [7:0] bexp [5];
            int pulses = 0;
            bops = '{4'd2, 4'd4, 4'd5, 4'd11, 4'd15};
            bin  = '{8'h01, 8'h30, 8'hFF, 8'h10, 8'h00};
            bexp = '{8'h10, 8'h10, 8'hEF, 8'hFF, 8'hFF};
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                bus.op = bops[i]; bus.inp = bin[i]; bus.in_valid = 1'b1;
                chk($sformatf("b2b%0d in_ready", i), bus.in_ready, 1);
                @(posedge clk); #1;
                if (bus.out_valid) pulses++;
                chk($sformatf("b2b%0d outp", i), bus.outp, bexp[i]);
                chk($sformatf("b2b%0d acc", i), bus.acc, bexp[i]);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk("b2b out_valid count", pulses, 5);
            chk("b2b op15 flag_z", bus.flag_z, 0);
            chk("b2b op15 flag_c", bus.flag_c, 0);
            @(posedge clk); #1;
            chk("b2b out_valid drops", bus.out_valid, 0);
        end

`ifdef ALU_SEQ_MUL_EN
        mul_run(8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0);
        mul_run(8'h20, 8'h10, 8'h00, 1'b1, 1'b1);

        // Reset three cycles into a multiply.
        begin
            int stray = 0;
            send(4'(OP_LDI), 8'h0C);
            send(4'(OP_MUL), 8'h0B);
            repeat (3) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("midmul rst acc", bus.acc, 0);
            chk("midmul rst in_ready", bus.in_ready, 1);
            chk("midmul rst out_valid", bus.out_valid, 0);
            chk("midmul rst flag_z", bus.flag_z, 1);
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk); #1;
                if (bus.out_valid) stray++;
            end
            chk("midmul no out_valid", stray, 0);
            send(4'(OP_LDI), 8'h42);
            chk("midmul next ldi out_valid", bus.out_valid, 1);
            chk("midmul next ldi acc", bus.acc, 8'h42);
        end
`else
        // Opcode 12 without the multiplier: one-cycle NOP.
        send(4'(OP_LDI), 8'h33);
        send(4'(OP_MUL), 8'h07);
        chk("op12 nop out_valid", bus.out_valid, 1);
        chk("op12 nop outp", bus.outp, 8'h33);
        chk("op12 nop acc", bus.acc, 8'h33);
        chk("op12 nop in_ready", bus.in_ready, 1);
        chk("op12 nop flag_c", bus.flag_c, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog so the bench never hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
